// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the cpu_ctrl sequencer: opcodes, FSM states and
// datapath control codes.
package cpu_ctrl_pkg;

  localparam logic [4:0] OP_NOP   = 5'b00000;
  localparam logic [4:0] OP_HALT  = 5'b00001;
  localparam logic [4:0] OP_LDI   = 5'b00010;
  localparam logic [4:0] OP_ADD   = 5'b00011;
  localparam logic [4:0] OP_SUB   = 5'b00100;
  localparam logic [4:0] OP_AND   = 5'b00101;
  localparam logic [4:0] OP_OR    = 5'b00110;
  localparam logic [4:0] OP_LOAD  = 5'b01000;
  localparam logic [4:0] OP_STORE = 5'b01001;
  localparam logic [4:0] OP_JMP   = 5'b01010;
  localparam logic [4:0] OP_BZ    = 5'b01011;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALTED
  } state_e;

  localparam logic [1:0] PC_HOLD = 2'b00;
  localparam logic [1:0] PC_INC  = 2'b01;
  localparam logic [1:0] PC_JMP  = 2'b10;
  localparam logic [1:0] PC_REL  = 2'b11;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  localparam logic [1:0] WSEL_ALU = 2'b00;
  localparam logic [1:0] WSEL_IMM = 2'b01;
  localparam logic [1:0] WSEL_MEM = 2'b10;

  function automatic logic [4:0] opcode_of(input logic [15:0] instr);
    return instr[15:11];
  endfunction

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Purely combinational opcode classifier feeding the cpu_ctrl FSM.
module cpu_ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [4:0] opcode_i,
  output logic       is_alu_o,
  output logic       is_ldi_o,
  output logic       is_mem_o,
  output logic       is_store_o,
  output logic       is_branch_o,
  output logic       is_bz_o,
  output logic       is_halt_o,
  output logic       is_illegal_o,
  output logic [1:0] alu_op_o,
  output logic [1:0] wsel_o
);

  always_comb begin
    is_alu_o     = 1'b0;
    is_ldi_o     = 1'b0;
    is_mem_o     = 1'b0;
    is_store_o   = 1'b0;
    is_branch_o  = 1'b0;
    is_bz_o      = 1'b0;
    is_halt_o    = 1'b0;
    is_illegal_o = 1'b0;
    alu_op_o     = ALU_ADD;
    wsel_o       = WSEL_ALU;
    case (opcode_i)
      OP_NOP:   ;
      OP_HALT:  is_halt_o = 1'b1;
      OP_LDI: begin
        is_ldi_o = 1'b1;
        wsel_o   = WSEL_IMM;
      end
      OP_ADD: begin
        is_alu_o = 1'b1;
        alu_op_o = ALU_ADD;
      end
      OP_SUB: begin
        is_alu_o = 1'b1;
        alu_op_o = ALU_SUB;
      end
      OP_AND: begin
        is_alu_o = 1'b1;
        alu_op_o = ALU_AND;
      end
      OP_OR: begin
        is_alu_o = 1'b1;
        alu_op_o = ALU_OR;
      end
      OP_LOAD: begin
        is_mem_o = 1'b1;
        wsel_o   = WSEL_MEM;
      end
      OP_STORE: begin
        is_mem_o   = 1'b1;
        is_store_o = 1'b1;
      end
      OP_JMP:   is_branch_o = 1'b1;
      OP_BZ: begin
        is_branch_o = 1'b1;
        is_bz_o     = 1'b1;
      end
      default:  is_illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl.sv
// Multi-cycle fetch/decode/execute sequencer: FSM, instruction register and
// output decode. Define CPU_CTRL_TRAP_EN to trap illegal opcodes into HALTED.
module cpu_ctrl
  import cpu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  input  logic        alu_zero,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        pc_en,
  output logic [1:0]  pc_ctrl,
  output logic [7:0]  offset_addr,
  output logic [15:0] ir,
  output logic [1:0]  alu_op,
  output logic        reg_we,
  output logic [1:0]  reg_wsel,
  output logic        busy,
  output logic        halted
`ifdef CPU_CTRL_TRAP_EN
  ,
  output logic        illegal
`endif
);

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;

  logic       dec_alu, dec_ldi, dec_mem, dec_store;
  logic       dec_branch, dec_bz, dec_halt, dec_illegal;
  logic [1:0] dec_alu_op, dec_wsel;

  cpu_ctrl_decode u_decode (
    .opcode_i     (opcode_of(ir_q)),
    .is_alu_o     (dec_alu),
    .is_ldi_o     (dec_ldi),
    .is_mem_o     (dec_mem),
    .is_store_o   (dec_store),
    .is_branch_o  (dec_branch),
    .is_bz_o      (dec_bz),
    .is_halt_o    (dec_halt),
    .is_illegal_o (dec_illegal),
    .alu_op_o     (dec_alu_op),
    .wsel_o       (dec_wsel)
  );

`ifdef CPU_CTRL_TRAP_EN
  logic illegal_q, illegal_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) illegal_q <= 1'b0;
    else      illegal_q <= illegal_d;
  end

  assign illegal = illegal_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ir_d         = ir_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    pc_en        = 1'b0;
    pc_ctrl      = PC_HOLD;
    alu_op       = ALU_ADD;
    reg_we       = 1'b0;
    reg_wsel     = WSEL_ALU;
`ifdef CPU_CTRL_TRAP_EN
    illegal_d    = illegal_q;
`endif
    case (state_q)
      S_IDLE: if (start) state_d = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_d    = mem_rdata;
          pc_en   = 1'b1;
          pc_ctrl = PC_INC;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (dec_illegal) begin
`ifdef CPU_CTRL_TRAP_EN
          illegal_d = 1'b1;
          state_d   = S_HALTED;
`else
          state_d   = S_FETCH;
`endif
        end else if (dec_halt) begin
          state_d = S_HALTED;
        end else if (dec_alu || dec_ldi) begin
          alu_op  = dec_alu_op;
          state_d = S_WB;
        end else if (dec_mem) begin
          state_d = S_MEM;
        end else begin
          // Branch target comes from offset_addr; the PC has already been
          // incremented in FETCH, so BZ is relative to the next instruction.
          if (dec_branch && !dec_bz) begin
            pc_en   = 1'b1;
            pc_ctrl = PC_JMP;
          end else if (dec_bz && alu_zero) begin
            pc_en   = 1'b1;
            pc_ctrl = PC_REL;
          end
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = dec_store;
        if (mem_ack) state_d = dec_store ? S_FETCH : S_WB;
      end
      S_WB: begin
        reg_we   = 1'b1;
        reg_wsel = dec_wsel;
        state_d  = S_FETCH;
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  assign ir          = ir_q;
  assign offset_addr = ir_q[7:0];
  assign busy        = (state_q != S_IDLE) && (state_q != S_HALTED);
  assign halted      = (state_q == S_HALTED);

endmodule

// File: tb/tb_cpu_ctrl.sv
// Randomized self-checking bench for cpu_ctrl against an instruction-level
// model (PC semantics, cycle budget, write-back and memory phases).
module tb_cpu_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic        alu_zero = 1'b0;
  logic        mem_req, mem_we, mem_addr_sel, pc_en;
  logic [1:0]  pc_ctrl, alu_op, reg_wsel;
  logic [7:0]  offset_addr;
  logic [15:0] ir;
  logic        reg_we, busy, halted;
`ifdef CPU_CTRL_TRAP_EN
  logic        illegal;
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  cpu_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .alu_zero     (alu_zero),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr_sel (mem_addr_sel),
    .pc_en        (pc_en),
    .pc_ctrl      (pc_ctrl),
    .offset_addr  (offset_addr),
    .ir           (ir),
    .alu_op       (alu_op),
    .reg_we       (reg_we),
    .reg_wsel     (reg_wsel),
    .busy         (busy),
    .halted       (halted)
`ifdef CPU_CTRL_TRAP_EN
    ,
    .illegal      (illegal)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [15:0] pc_hw;   // PC register emulated from the DUT's pc_en/pc_ctrl
  logic [15:0] pc_m;    // architectural PC from instruction semantics
  logic        ill_m;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic bit legal_op(input logic [4:0] op);
    return (op <= 5'd6) || (op >= 5'd8 && op <= 5'd11);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; start = 1'b0; mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("reset_ir", {16'h0, ir}, 32'h0);
    check_eq("reset_outs", {mem_req, mem_we, mem_addr_sel, pc_en, pc_ctrl, offset_addr,
                            alu_op, reg_we, reg_wsel, busy, halted}, 32'h0);
`ifdef CPU_CTRL_TRAP_EN
    check_eq("reset_illegal", {31'h0, illegal}, 32'h0);
`endif
    pc_hw = '0; pc_m = '0; ill_m = 1'b0;
    rst = 1'b1;
  endtask

  // Leaves the bench at negedge+1 of the first FETCH cycle.
  task automatic start_run();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
  endtask

  // zsel: 0/1 forces alu_zero, 2 randomizes it every cycle.
  task automatic run_instr(input logic [15:0] instr, input int unsigned fw,
                           input int unsigned mw, input int unsigned zsel);
    logic [4:0]  op;
    int unsigned cyc, ack_cyc, fwait, mwait, pulses, writes, memcyc, wecyc;
    int unsigned exp_cyc, exp_pulses, exp_writes;
    logic        fetched, done, z_exec, is_alu, wb, exp_halt;
    logic [1:0]  wsel_seen, aluop_seen, exp_wsel;
    op = instr[15:11];
    cyc = 0; ack_cyc = 0; fwait = 0; mwait = 0; pulses = 0; writes = 0;
    memcyc = 0; wecyc = 0; fetched = 1'b0; done = 1'b0; z_exec = 1'b0;
    wsel_seen = '0; aluop_seen = '0;
    while (!done && cyc < 40) begin
      if (fetched && ((mem_req && !mem_addr_sel) || halted)) begin
        done = 1'b1;
      end else begin
        alu_zero  = (zsel == 2) ? 1'($urandom_range(0, 1)) : zsel[0];
        start     = 1'($urandom_range(0, 1));
        mem_rdata = 16'($urandom);
        if (mem_req && !mem_addr_sel) begin
          if (fwait == fw) begin mem_ack = 1'b1; mem_rdata = instr; end
          else fwait++;
        end else if (mem_req) begin
          memcyc++;
          if (mem_we) wecyc++;
          if (mwait == mw) mem_ack = 1'b1;
          else mwait++;
        end else begin
          mem_ack = 1'($urandom_range(0, 1));
        end
        #1;
        if (pc_en) begin
          pulses++;
          case (pc_ctrl)
            2'b01:   pc_hw = pc_hw + 16'd1;
            2'b10:   pc_hw = {8'h00, offset_addr};
            2'b11:   pc_hw = pc_hw + {8'h00, offset_addr};
            default: ;
          endcase
        end
        if (reg_we) begin writes++; wsel_seen = reg_wsel; end
        if (fetched && cyc == ack_cyc + 2) begin aluop_seen = alu_op; z_exec = alu_zero; end
        if (!fetched && mem_ack && mem_req && !mem_addr_sel) begin
          fetched = 1'b1; ack_cyc = cyc;
        end
        cyc++;
        @(negedge clk);
        mem_ack = 1'b0; start = 1'b0;
        #1;
      end
    end
    check_eq("instr_done", {31'h0, done}, 32'h1);

    is_alu     = (op >= 5'd3 && op <= 5'd6);
    wb         = is_alu || op == 5'd2 || op == 5'd8;
    exp_halt   = (op == 5'd1) || (TRAP && !legal_op(op));
    exp_cyc    = fw + 3 + (wb ? 1 : 0) + ((op == 5'd8 || op == 5'd9) ? mw + 1 : 0);
    pc_m       = pc_m + 16'd1;
    exp_pulses = 1;
    if (op == 5'd10) begin pc_m = {8'h00, instr[7:0]}; exp_pulses = 2; end
    if (op == 5'd11 && z_exec) begin pc_m = pc_m + {8'h00, instr[7:0]}; exp_pulses = 2; end
    exp_writes = wb ? 1 : 0;
    exp_wsel   = (op == 5'd2) ? 2'b01 : (op == 5'd8) ? 2'b10 : 2'b00;
    if (TRAP && !legal_op(op)) ill_m = 1'b1;

    check_eq("cycles", cyc, exp_cyc);
    check_eq("pc", {16'h0, pc_hw}, {16'h0, pc_m});
    check_eq("pc_pulses", pulses, exp_pulses);
    check_eq("reg_writes", writes, exp_writes);
    if (wb) check_eq("reg_wsel", {30'h0, wsel_seen}, {30'h0, exp_wsel});
    if (is_alu) check_eq("alu_op", {30'h0, aluop_seen}, {27'h0, op - 5'd3});
    check_eq("mem_cycles", memcyc, (op == 5'd8 || op == 5'd9) ? mw + 1 : 0);
    check_eq("we_cycles", wecyc, (op == 5'd9) ? mw + 1 : 0);
    check_eq("ir", {16'h0, ir}, {16'h0, instr});
    check_eq("offset_addr", {24'h0, offset_addr}, {24'h0, instr[7:0]});
    check_eq("halted", {31'h0, halted}, {31'h0, exp_halt});
`ifdef CPU_CTRL_TRAP_EN
    check_eq("illegal", {31'h0, illegal}, {31'h0, ill_m});
`endif
  endtask

  task automatic halted_checks();
    check_eq("halt_busy", {31'h0, busy}, 32'h0);
    start = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      check_eq("halt_sticky", {30'h0, halted, mem_req}, 32'h2);
    end
    start = 1'b0;
  endtask

  task automatic reset_in_mem();
    int unsigned n;
    do_reset();
    start_run();
    n = 0;
    while (!(mem_req && !mem_addr_sel) && n < 10) begin @(negedge clk); #1; n++; end
    mem_ack = 1'b1; mem_rdata = 16'h4120;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    n = 0;
    while (!(mem_req && mem_addr_sel) && n < 10) begin @(negedge clk); #1; n++; end
    @(negedge clk);
    #1;
    check_eq("mem_wait_req", {30'h0, mem_req, mem_addr_sel}, 32'h3);
    rst = 1'b0;
    #1;
    check_eq("async_drop", {29'h0, mem_req, pc_en, busy}, 32'h0);
    check_eq("async_ir", {16'h0, ir}, 32'h0);
    #1;
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_eq("post_reset_idle", {30'h0, busy, mem_req}, 32'h0);
  endtask

  logic [4:0] legal_tab [10] = '{5'd0, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd8, 5'd9, 5'd10, 5'd11};

  initial begin
    logic [4:0]  op;
    logic [15:0] instr;

    do_reset();
    start_run();
    run_instr(16'h1305, 0, 0, 2);
    run_instr(16'h4120, 0, 3, 2);
    run_instr(16'h5810, 0, 0, 1);
    run_instr(16'h5810, 0, 0, 0);
    run_instr(16'h50FF, 0, 0, 2);
    run_instr(16'hF800, 0, 0, 2);
    if (!TRAP) run_instr(16'h0800, 1, 0, 2);
    halted_checks();

    for (int r = 0; r < 3; r++) begin
      do_reset();
      start_run();
      for (int i = 0; i < 50; i++) begin
        if ($urandom_range(0, 15) == 0) op = 5'($urandom_range(0, 31));
        else op = legal_tab[$urandom_range(0, 9)];
        instr = {op, 11'($urandom)};
        run_instr(instr, $urandom_range(0, 2), $urandom_range(0, 3), 2);
        if (halted) break;
      end
      if (halted) halted_checks();
    end

    reset_in_mem();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
